// File: rtl/output_port_arbiter.sv
// Round-robin arbiter for one router output port.
// Four input ports offer routed flits. One flit per cycle is granted into a
// single-entry output register, which is held while downstream asserts portBlock.
module output_port_arbiter #(
    parameter int modifiedFlitSize = 32,
    parameter int countWidth       = 16
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [modifiedFlitSize-1:0] inFlit1,
    input  logic [modifiedFlitSize-1:0] inFlit2,
    input  logic [modifiedFlitSize-1:0] inFlit3,
    input  logic [modifiedFlitSize-1:0] inFlit4,
    input  logic [3:0]                  inValid,
    output logic [3:0]                  inReady,
    output logic [modifiedFlitSize-1:0] outFlit,
    output logic                        outValid,
    input  logic                        portBlock,
    output logic [3:0]                  grantOut,
    output logic [countWidth-1:0]       outCount
);

    typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;

    state_t                      state;
    logic [1:0]                  ptr;
    logic                        deliver;
    logic                        canLoad;
    logic                        found;
    logic [1:0]                  winner;
    logic                        transfer;
    logic [modifiedFlitSize-1:0] selFlit;

    function automatic logic [3:0] onehot4(input logic [1:0] idx);
        logic [3:0] r;
        r = 4'b0000;
        r[idx] = 1'b1;
        return r;
    endfunction

    // The state register is the outValid flag itself.
    assign outValid = (state == SEND);
    assign deliver  = outValid & ~portBlock;
    assign canLoad  = ~outValid | deliver;

    // Scan requests from ptr upward, wrapping 3 -> 0; first set bit wins.
    always_comb begin
        found  = 1'b0;
        winner = ptr;
        for (int k = 0; k < 4; k++) begin
            logic [1:0] idx;
            idx = ptr + 2'(k);
            if (!found && inValid[idx]) begin
                found  = 1'b1;
                winner = idx;
            end
        end
    end

    assign transfer = canLoad & found;
    assign inReady  = transfer ? onehot4(winner) : 4'b0000;

    // Select the flit of the winning port.
    always_comb begin
        selFlit = inFlit1;
        case (winner)
            2'd0: selFlit = inFlit1;
            2'd1: selFlit = inFlit2;
            2'd2: selFlit = inFlit3;
            2'd3: selFlit = inFlit4;
            default: selFlit = inFlit1;
        endcase
    end

    // Output register, grant, priority pointer and delivered-flit counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            outFlit  <= '0;
            grantOut <= 4'b0000;
            outCount <= '0;
            ptr      <= 2'd0;
        end else begin
            if (deliver) begin
                outCount <= outCount + countWidth'(1);
            end
            if (transfer) begin
                outFlit  <= selFlit;
                grantOut <= onehot4(winner);
                state    <= SEND;
                ptr      <= winner + 2'd1;
            end else if (deliver) begin
                // Flit left and nothing replaces it; outFlit keeps its stale value.
                state    <= IDLE;
                grantOut <= 4'b0000;
            end
        end
    end

endmodule

// File: tb/tb_output_port_arbiter.sv
// Bench for output_port_arbiter: a vector table driven cycle by cycle with
// post-edge expectations queued and popped, plus a narrow-counter wrap sequence.
module tb_output_port_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] inFlit1, inFlit2, inFlit3, inFlit4;
    logic [3:0]  inValid;
    logic [3:0]  inReady;
    logic [31:0] outFlit;
    logic        outValid;
    logic        portBlock;
    logic [3:0]  grantOut;
    logic [15:0] outCount;

    logic        reset4;
    logic [3:0]  inValid4;
    logic [3:0]  inReady4;
    logic [31:0] outFlit4;
    logic        outValid4;
    logic [3:0]  grantOut4;
    logic [3:0]  outCount4;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    output_port_arbiter #(.modifiedFlitSize(32), .countWidth(16)) dut (
        .clk(clk), .reset(reset),
        .inFlit1(inFlit1), .inFlit2(inFlit2), .inFlit3(inFlit3), .inFlit4(inFlit4),
        .inValid(inValid), .inReady(inReady),
        .outFlit(outFlit), .outValid(outValid), .portBlock(portBlock),
        .grantOut(grantOut), .outCount(outCount)
    );

    output_port_arbiter #(.modifiedFlitSize(32), .countWidth(4)) dut4 (
        .clk(clk), .reset(reset4),
        .inFlit1(inFlit1), .inFlit2(inFlit2), .inFlit3(inFlit3), .inFlit4(inFlit4),
        .inValid(inValid4), .inReady(inReady4),
        .outFlit(outFlit4), .outValid(outValid4), .portBlock(1'b0),
        .grantOut(grantOut4), .outCount(outCount4)
    );

    typedef struct {
        logic        rst;
        logic [3:0]  iv;
        logic        pb;
        logic [3:0]  rdy;
        logic        ov;
        logic [3:0]  g;
        logic [15:0] c;
    } vec_t;

    typedef struct {
        logic        ov;
        logic [3:0]  g;
        logic [31:0] f;
        logic [15:0] c;
    } exp_t;

    vec_t vt[$];
    exp_t sbq[$];

    localparam logic [31:0] F1 = 32'hA5A5_0001;
    localparam logic [31:0] F2 = 32'h3C3C_0002;
    localparam logic [31:0] F3 = 32'h0FF0_0004;
    localparam logic [31:0] F4 = 32'hF00F_0008;

    function automatic logic [31:0] flit_of(input logic [3:0] g);
        case (g)
            4'b0001: return F1;
            4'b0010: return F2;
            4'b0100: return F3;
            4'b1000: return F4;
            default: return 32'h0;
        endcase
    endfunction

    task automatic add(input logic rst, input logic [3:0] iv, input logic pb,
                       input logic [3:0] rdy, input logic ov, input logic [3:0] g,
                       input logic [15:0] c);
        vec_t v;
        v.rst = rst; v.iv = iv; v.pb = pb; v.rdy = rdy; v.ov = ov; v.g = g; v.c = c;
        vt.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
        end
    endtask

    initial begin
        exp_t        e;
        exp_t        got;
        logic [31:0] model_flit;

        inFlit1 = F1; inFlit2 = F2; inFlit3 = F3; inFlit4 = F4;
        reset = 1'b1; inValid = 4'b0; portBlock = 1'b0;
        reset4 = 1'b1; inValid4 = 4'b0;
        model_flit = 32'h0;

        //   rst  inValid  pb  inReady  oV  grant    count
        add(1'b1, 4'b0000, 0, 4'b0000, 0, 4'b0000, 16'd0);
        // single request from port 1, then delivery
        add(1'b0, 4'b0001, 0, 4'b0001, 1, 4'b0001, 16'd0);
        add(1'b0, 4'b0000, 0, 4'b0000, 0, 4'b0000, 16'd1);
        add(1'b1, 4'b0000, 0, 4'b0000, 0, 4'b0000, 16'd0);
        // all four requesting: full-rate rotation
        add(1'b0, 4'b1111, 0, 4'b0001, 1, 4'b0001, 16'd0);
        add(1'b0, 4'b1111, 0, 4'b0010, 1, 4'b0010, 16'd1);
        add(1'b0, 4'b1111, 0, 4'b0100, 1, 4'b0100, 16'd2);
        add(1'b0, 4'b1111, 0, 4'b1000, 1, 4'b1000, 16'd3);
        add(1'b0, 4'b1111, 0, 4'b0001, 1, 4'b0001, 16'd4);
        add(1'b0, 4'b1111, 0, 4'b0010, 1, 4'b0010, 16'd5);
        add(1'b0, 4'b1111, 0, 4'b0100, 1, 4'b0100, 16'd6);
        add(1'b0, 4'b1111, 0, 4'b1000, 1, 4'b1000, 16'd7);
        add(1'b0, 4'b0000, 0, 4'b0000, 0, 4'b0000, 16'd8);
        // port 3 loaded, then blocked 5 cycles, then released -> port 4
        add(1'b0, 4'b0100, 0, 4'b0100, 1, 4'b0100, 16'd8);
        add(1'b0, 4'b1111, 1, 4'b0000, 1, 4'b0100, 16'd8);
        add(1'b0, 4'b1111, 1, 4'b0000, 1, 4'b0100, 16'd8);
        add(1'b0, 4'b1111, 1, 4'b0000, 1, 4'b0100, 16'd8);
        add(1'b0, 4'b1111, 1, 4'b0000, 1, 4'b0100, 16'd8);
        add(1'b0, 4'b1111, 1, 4'b0000, 1, 4'b0100, 16'd8);
        add(1'b0, 4'b1111, 0, 4'b1000, 1, 4'b1000, 16'd9);
        add(1'b0, 4'b0000, 0, 4'b0000, 0, 4'b0000, 16'd10);
        // sparse: port 2, idle (no rotation), then 0011 -> port 1
        add(1'b0, 4'b0010, 0, 4'b0010, 1, 4'b0010, 16'd10);
        add(1'b0, 4'b0000, 0, 4'b0000, 0, 4'b0000, 16'd11);
        add(1'b0, 4'b0000, 0, 4'b0000, 0, 4'b0000, 16'd11);
        add(1'b0, 4'b0000, 0, 4'b0000, 0, 4'b0000, 16'd11);
        add(1'b0, 4'b0011, 0, 4'b0001, 1, 4'b0001, 16'd11);
        add(1'b0, 4'b0000, 0, 4'b0000, 0, 4'b0000, 16'd12);
        // portBlock ignored while idle
        add(1'b0, 4'b0000, 1, 4'b0000, 0, 4'b0000, 16'd12);
        add(1'b0, 4'b0010, 1, 4'b0010, 1, 4'b0010, 16'd12);
        // reset while holding a blocked flit
        add(1'b0, 4'b1111, 1, 4'b0000, 1, 4'b0010, 16'd12);
        add(1'b1, 4'b1111, 1, 4'b0000, 0, 4'b0000, 16'd0);
        add(1'b0, 4'b1111, 1, 4'b0001, 1, 4'b0001, 16'd0);
        add(1'b0, 4'b0000, 0, 4'b0000, 0, 4'b0000, 16'd1);

        for (int i = 0; i < vt.size(); i++) begin
            reset     = vt[i].rst;
            inValid   = vt[i].iv;
            portBlock = vt[i].pb;
            #1;
            if (!vt[i].rst) chk($sformatf("inReady[%0d]", i), 32'(inReady), 32'(vt[i].rdy));
            if (vt[i].rst) model_flit = 32'h0;
            else if (vt[i].g != 4'b0) model_flit = flit_of(vt[i].g);
            e.ov = vt[i].ov; e.g = vt[i].g; e.f = model_flit; e.c = vt[i].c;
            sbq.push_back(e);
            @(posedge clk);
            #1;
            got = sbq.pop_front();
            chk($sformatf("outValid[%0d]", i), 32'(outValid), 32'(got.ov));
            chk($sformatf("grantOut[%0d]", i), 32'(grantOut), 32'(got.g));
            chk($sformatf("outFlit[%0d]", i), outFlit, got.f);
            chk($sformatf("outCount[%0d]", i), 32'(outCount), 32'(got.c));
        end

        // 4-bit counter: 17 back-to-back grants then drain -> count wraps to 1
        reset = 1'b0; inValid = 4'b0; portBlock = 1'b0;
        reset4 = 1'b1; inValid4 = 4'b0;
        @(posedge clk); #1;
        chk("w4_reset_cnt", 32'(outCount4), 32'd0);
        reset4 = 1'b0; inValid4 = 4'b1111;
        for (int k = 1; k <= 17; k++) begin
            if (k == 17) begin
                #1;
                chk("w4_inReady17", 32'(inReady4), 32'b0001);
            end
            @(posedge clk); #1;
            if (k == 16) chk("w4_cnt15", 32'(outCount4), 32'd15);
        end
        chk("w4_cnt_wrap0", 32'(outCount4), 32'd0);
        chk("w4_grant17", 32'(grantOut4), 32'b0001);
        chk("w4_flit17", outFlit4, F1);
        inValid4 = 4'b0;
        @(posedge clk); #1;
        chk("w4_cnt_final", 32'(outCount4), 32'd1);
        chk("w4_valid_final", 32'(outValid4), 32'd0);

        if (sbq.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_leftover: got %0d entries, expected 0", sbq.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
